psum_collector: RTL and testbench

- Stage directly upstream of the write-back controller: consumes skewed per-column partial sums leaving the systolic array bottom edge.
- Deskews them, requantizes each to 8 bits (arithmetic shift + saturate) and packs one aligned row into one `WORD_SIZE word.
- Buffers words in a small FIFO; drives the write-back controller's DI_valid/DI stream.
- Raises a stall to the array when the FIFO cannot absorb the skew tail.

---
 rtl/psum_collector_pkg.sv | 20 ++
 rtl/psum_collector_sync_fifo.sv | 60 ++++++
 rtl/psum_collector.sv | 191 +++++++++++++++++++
 tb/tb_psum_collector.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_collector_pkg.sv
// Shared constants and state encoding for the partial-sum collector and its neighbours.
// Word/counter widths match the write-back controller interface.
package psum_collector_pkg;

    localparam int unsigned WordSize     = 32;
    localparam int unsigned DataMaxBits  = 8;
    localparam int unsigned PsumWDefault = 24;

    // Saturation bounds for requantization to signed 8 bits
    localparam int signed Int8Max = 127;
    localparam int signed Int8Min = -128;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StDrain   = 2'd2,
        StDone    = 2'd3
    } collector_state_e;

endpackage

// File: rtl/psum_collector_sync_fifo.sv
// Synchronous FIFO with occupancy count; head word is read straight from the storage registers.
// Depth must be a power of two so the pointers wrap naturally.
module psum_collector_sync_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [Width-1:0]         data_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         data_o,
    output logic                     valid_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam int unsigned CntW  = AddrW + 1;
    localparam logic [CntW-1:0] Full = CntW'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wptr_q;
    logic [AddrW-1:0] rptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push_i && ((count_q != Full) || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= data_i;
                wptr_q        <= wptr_q + AddrW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AddrW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem_q[rptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/psum_collector.sv
// Deskews per-column partial sums from the array bottom edge, requantizes them to int8 and
// packs each aligned row into one word queued toward the write-back controller.
module psum_collector
    import psum_collector_pkg::*;
#(
    parameter int unsigned COLS       = 4,
    parameter int unsigned PSUM_W     = PsumWDefault,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     config_valid,
    input  logic [DataMaxBits-1:0]   num_rows,
    input  logic [4:0]               shift,
    input  logic [COLS-1:0]          col_valid,
    input  logic [COLS*PSUM_W-1:0]   col_data,
    output logic                     array_stall,
    output logic                     DI_valid,
    output logic [WordSize-1:0]      DI,
    input  logic                     DI_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
    // Stall once fewer than COLS+1 entries are free
    localparam logic [CntW-1:0] StallCount = CntW'(FIFO_DEPTH - COLS);
    localparam logic signed [PSUM_W-1:0] SatHi = PSUM_W'(Int8Max);
    localparam logic signed [PSUM_W-1:0] SatLo = PSUM_W'(Int8Min);

    function automatic logic [7:0] requant(input logic [PSUM_W-1:0] v, input logic [4:0] sh);
        logic signed [PSUM_W-1:0] s;
        s = $signed(v) >>> sh;
        if (s > SatHi) begin
            requant = 8'h7f;
        end else if (s < SatLo) begin
            requant = 8'h80;
        end else begin
            requant = s[7:0];
        end
    endfunction

    logic [COLS-1:0]             dv;
    logic [COLS-1:0][PSUM_W-1:0] dd;
    logic                        row_ok;
    logic                        row_bad;
    logic                        accept;
    logic                        pack_valid_q;
    logic [WordSize-1:0]         pack_data_q;
    logic [WordSize-1:0]         pack_data_d;
    logic [CntW-1:0]             fifo_count;
    logic                        pop;
    logic                        last_pop;
    collector_state_e            state_q;
    logic [DataMaxBits-1:0]      num_rows_q;
    logic [DataMaxBits-1:0]      rows_q;
    logic [DataMaxBits-1:0]      rows_inc;
    logic [4:0]                  shift_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        err_q;

    // Column c is delayed COLS-1-c cycles so all columns of one row line up
    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int unsigned D = COLS - 1 - c;
        if (D == 0) begin : g_pass
            assign dv[c] = col_valid[c];
            assign dd[c] = col_data[c*PSUM_W +: PSUM_W];
        end else begin : g_dly
            logic [D-1:0]             v_q;
            logic [D-1:0][PSUM_W-1:0] d_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    v_q <= '0;
                    d_q <= '0;
                end else if (!array_stall) begin
                    v_q[0] <= col_valid[c];
                    d_q[0] <= col_data[c*PSUM_W +: PSUM_W];
                    for (int i = 1; i < D; i++) begin
                        v_q[i] <= v_q[i-1];
                        d_q[i] <= d_q[i-1];
                    end
                end
            end
            assign dv[c] = v_q[D-1];
            assign dd[c] = d_q[D-1];
        end
    end

    // Nothing is consumed from the delay lines while they are frozen
    assign row_ok  = !array_stall && (&dv);
    assign row_bad = !array_stall && (|dv) && !(&dv);
    assign accept  = row_ok && (state_q == StCollect);

    always_comb begin
        pack_data_d = '0;
        for (int c = 0; c < COLS; c++) begin
            pack_data_d[c*8 +: 8] = requant(dd[c], shift_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pack_valid_q <= 1'b0;
            pack_data_q  <= '0;
        end else begin
            pack_valid_q <= accept;
            if (accept) begin
                pack_data_q <= pack_data_d;
            end
        end
    end

    psum_collector_sync_fifo #(
        .Width (WordSize),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pack_valid_q),
        .data_i  (pack_data_q),
        .pop_i   (pop),
        .data_o  (DI),
        .valid_o (DI_valid),
        .count_o (fifo_count)
    );

    assign pop         = DI_valid && DI_ready;
    assign array_stall = (fifo_count >= StallCount);
    assign rows_inc    = rows_q + DataMaxBits'(1);
    // Final word leaves this cycle and nothing remains queued or in flight
    assign last_pop    = !pack_valid_q &&
                         ((fifo_count == '0) || ((fifo_count == CntW'(1)) && pop));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            num_rows_q <= '0;
            rows_q     <= '0;
            shift_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (config_valid) begin
                        num_rows_q <= num_rows;
                        shift_q    <= shift;
                        rows_q     <= '0;
                        err_q      <= 1'b0;
                        if (num_rows == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= StCollect;
                        end
                    end
                end
                StCollect: begin
                    if (accept) begin
                        rows_q <= rows_inc;
                        if (rows_inc == num_rows_q) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (last_pop) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
            // Misaligned valids or rows beyond the job length are dropped and flagged
            if (row_bad || (row_ok && (state_q != StCollect))) begin
                err_q <= 1'b1;
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: skewed column feeder that honours array_stall,
// output word capture, and hand-computed expected words.
module tb_psum_collector;

    localparam int Cols = 4;
    localparam int PsumW = 24;

    logic              clk = 1'b0;
    logic              rst;
    logic              config_valid;
    logic [7:0]        num_rows;
    logic [4:0]        shift;
    logic [Cols-1:0]   col_valid;
    logic [Cols*PsumW-1:0] col_data;
    logic              array_stall;
    logic              DI_valid;
    logic [31:0]       DI;
    logic              DI_ready;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    psum_collector #(
        .COLS       (Cols),
        .PSUM_W     (PsumW),
        .FIFO_DEPTH (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .config_valid (config_valid),
        .num_rows     (num_rows),
        .shift        (shift),
        .col_valid    (col_valid),
        .col_data     (col_data),
        .array_stall  (array_stall),
        .DI_valid     (DI_valid),
        .DI           (DI),
        .DI_ready     (DI_ready),
        .busy         (busy),
        .done         (done)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    logic [PsumW-1:0] rows_mem [32][Cols];
    logic [31:0]      got [$];
    int  cyc = 0;
    int  feed_k = 0;
    int  feed_rows = 0;
    bit  feeding = 0;
    bit  stall_last = 0;
    int  rdy_lo_from = 0;
    int  rdy_lo_to = 0;
    int  cfg_inject = -1;
    int  done_cnt, done_cyc, first_dv, first_col0, cfg_cyc;
    bit  stall_seen, busy_seen;

    task automatic set_row(input int r, input logic [PsumW-1:0] c0, input logic [PsumW-1:0] c1,
                           input logic [PsumW-1:0] c2, input logic [PsumW-1:0] c3);
        rows_mem[r][0] = c0;
        rows_mem[r][1] = c1;
        rows_mem[r][2] = c2;
        rows_mem[r][3] = c3;
    endtask

    task automatic drive_cols();
        for (int c = 0; c < Cols; c++) begin
            int r;
            r = feed_k - c;
            if (feeding && r >= 0 && r < feed_rows) begin
                col_valid[c] = 1'b1;
                col_data[c*PsumW +: PsumW] = rows_mem[r][c];
            end else begin
                col_valid[c] = 1'b0;
                col_data[c*PsumW +: PsumW] = '0;
            end
        end
    endtask

    // Advance one clock; observe outputs 1 time unit after the edge, then drive the new cycle
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (array_stall) stall_seen = 1;
        if (busy) busy_seen = 1;
        if (DI_valid && first_dv < 0) first_dv = cyc;
        DI_ready = !(cyc >= rdy_lo_from && cyc < rdy_lo_to);
        if (DI_valid && DI_ready) got.push_back(DI);
        if (cyc == cfg_inject) begin
            config_valid = 1'b1;
            num_rows = 8'd0;
        end else begin
            config_valid = 1'b0;
        end
        // The array holds its outputs in the cycle after array_stall was high
        if (feeding && !stall_last) feed_k++;
        stall_last = array_stall;
        drive_cols();
    endtask

    task automatic run_job(input int nrows, input int sh, input int nfeed, input int budget,
                           input int stop_words);
        got.delete();
        done_cnt = 0;
        done_cyc = -1;
        first_dv = -1;
        stall_seen = 0;
        busy_seen = 0;
        config_valid = 1'b1;
        num_rows = nrows[7:0];
        shift = sh[4:0];
        cfg_cyc = cyc;
        tick();
        feeding = 1;
        feed_rows = nfeed;
        feed_k = 0;
        stall_last = array_stall;
        first_col0 = cyc;
        drive_cols();
        for (int i = 0; i < budget; i++) begin
            if (done_cnt > 0 || (stop_words > 0 && got.size() >= stop_words)) break;
            tick();
        end
        if (stop_words == 0) repeat (4) tick();
        feeding = 0;
        drive_cols();
    endtask

    function automatic logic [31:0] seq_word(input int r);
        return {8'(r*4+4), 8'(r*4+3), 8'(r*4+2), 8'(r*4+1)};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        config_valid = 1'b0;
        num_rows = '0;
        shift = '0;
        col_valid = '0;
        col_data = '0;
        DI_ready = 1'b1;
        #3;
        check_eq("reset_outputs", {27'd0, array_stall, DI_valid, busy, done, 1'b0}, 32'd0);
        check_eq("reset_di", DI, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Single row, values 1..4
        set_row(0, 24'd1, 24'd2, 24'd3, 24'd4);
        run_job(1, 0, 1, 40, 0);
        check_eq("t1_count", got.size(), 1);
        check_eq("t1_word", got[0], 32'h04030201);
        check_eq("t1_dv_latency", first_dv - first_col0, Cols + 1);
        check_eq("t1_done_after_pop", done_cyc - first_dv, 1);
        check_eq("t1_done_once", done_cnt, 1);
        check_eq("t1_busy_idle", busy, 0);
        check_eq("t1_err", dut.err_q, 0);

        // Saturation, then shift by 8, then shift past the sign bit
        set_row(0, 24'h000200, 24'hFFFE00, 24'h00007F, 24'hFFFF7F);
        run_job(1, 0, 1, 40, 0);
        check_eq("t2_sat_word", got[0], 32'h807F807F);
        run_job(1, 8, 1, 40, 0);
        check_eq("t2_shift8_word", got[0], 32'hFF00FE02);
        set_row(0, 24'h7FFFFF, 24'h800000, 24'h000000, 24'hFFFFFF);
        run_job(1, 24, 1, 40, 0);
        check_eq("t2_shift24_word", got[0], 32'hFF00FF00);
        check_eq("t2_done_once", done_cnt, 1);

        // Back-pressure: 16 rows with DI_ready low for 20 cycles, plus an ignored config
        for (int r = 0; r < 16; r++) begin
            set_row(r, 24'(r*4+1), 24'(r*4+2), 24'(r*4+3), 24'(r*4+4));
        end
        rdy_lo_from = cyc + 1;
        rdy_lo_to = cyc + 21;
        cfg_inject = cyc + 11;
        run_job(16, 0, 16, 300, 0);
        cfg_inject = -1;
        check_eq("t3_count", got.size(), 16);
        for (int r = 0; r < 16; r++) begin
            check_eq($sformatf("t3_word%0d", r), got[r], seq_word(r));
        end
        check_eq("t3_stall_seen", stall_seen, 1);
        check_eq("t3_done_once", done_cnt, 1);
        check_eq("t3_err", dut.err_q, 0);

        // Zero-row job
        run_job(0, 0, 0, 10, 0);
        check_eq("t4_done_next", done_cyc - cfg_cyc, 1);
        check_eq("t4_done_once", done_cnt, 1);
        check_eq("t4_busy_never", busy_seen, 0);
        check_eq("t4_no_dv", first_dv, -1);

        // Reset in the middle of an 8-row job
        for (int r = 0; r < 8; r++) begin
            set_row(r, 24'(r*4+1), 24'(r*4+2), 24'(r*4+3), 24'(r*4+4));
        end
        run_job(8, 0, 8, 100, 3);
        check_eq("t5_pre_busy", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("t5_rst_flags", {28'd0, array_stall, DI_valid, busy, done}, 32'd0);
        check_eq("t5_rst_di", DI, 32'd0);
        check_eq("t5_no_done", done_cnt, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        set_row(0, 24'd17, 24'd18, 24'd19, 24'd20);
        set_row(1, 24'hFFFFFF, 24'hFFFFFE, 24'd100, 24'd0);
        run_job(2, 0, 2, 60, 0);
        check_eq("t5_count", got.size(), 2);
        check_eq("t5_word0", got[0], 32'h14131211);
        check_eq("t5_word1", got[1], 32'h0064FEFF);
        check_eq("t5_done_once", done_cnt, 1);

        // Extra aligned row after the job length is reached
        for (int r = 0; r < 3; r++) begin
            set_row(r, 24'(r*4+1), 24'(r*4+2), 24'(r*4+3), 24'(r*4+4));
        end
        run_job(2, 0, 3, 60, 0);
        check_eq("t6_count", got.size(), 2);
        check_eq("t6_word0", got[0], seq_word(0));
        check_eq("t6_word1", got[1], seq_word(1));
        check_eq("t6_err", dut.err_q, 1);
        check_eq("t6_done_once", done_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
